// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared FSM encodings, owner IDs and wait-counter helper for
//            the two-requester RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC     = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic OWN_0 = 1'b0;
    localparam logic OWN_1 = 1'b1;

    // Wide enough for RD_LAT-1 with RD_LAT in 1..3
    localparam int WAIT_CNT_W = 2;

    function automatic logic [WAIT_CNT_W-1:0] rd_wait_init(input int rd_lat);
        return WAIT_CNT_W'(rd_lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester and RAM-side signal bundle of the arbiter. The master
//            modport is the arbiter view, slave is the client/RAM view.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req_0;
    logic              we_0;
    logic [ADDR_W-1:0] addr_0;
    logic [DATA_W-1:0] wdata_0;
    logic              gnt_0;
    logic              rvld_0;
    logic [DATA_W-1:0] rdata_0;

    logic              req_1;
    logic              we_1;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_1;
    logic              gnt_1;
    logic              rvld_1;
    logic [DATA_W-1:0] rdata_1;

    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_rdaddr;
    logic [DATA_W-1:0] ram_q;

    logic              busy;

    modport master (
        input  req_0, we_0, addr_0, wdata_0,
        input  req_1, we_1, addr_1, wdata_1,
        input  ram_q,
        output gnt_0, rvld_0, rdata_0,
        output gnt_1, rvld_1, rdata_1,
        output ram_wren, ram_wraddr, ram_wdata, ram_rdaddr,
        output busy
    );

    modport slave (
        output req_0, we_0, addr_0, wdata_0,
        output req_1, we_1, addr_1, wdata_1,
        output ram_q,
        input  gnt_0, rvld_0, rdata_0,
        input  gnt_1, rvld_1, rdata_1,
        input  ram_wren, ram_wraddr, ram_wdata, ram_rdaddr,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way picker; round-robin on last winner, or
//            fixed priority to requester 0 when 'fixed' is set.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       win,
    output logic       any
);

    always_comb begin
        any = |req;
        win = OWN_0;
        if (req == 2'b11) begin
            win = fixed ? OWN_0 : ~last;
        end else if (req[1]) begin
            win = OWN_1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one dual-port RAM between two requesters, sequencing
//            strictly non-overlapping writes and reads with read-data return.
//            Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0
//            wins ties, requester 1 may starve); default is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1    // legal range 1..3
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.master  bus
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam logic c_FIXED_PRIO = 1'b1;
`else
    localparam logic c_FIXED_PRIO = 1'b0;
`endif

    state_t                r_state;
    logic                  r_cmd_owner;
    logic                  r_cmd_we;
    logic [ADDR_W-1:0]     r_cmd_addr;
    logic [DATA_W-1:0]     r_cmd_wdata;
    logic                  r_last_gnt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_gnt_0;
    logic                  r_gnt_1;
    logic                  r_rvld_0;
    logic                  r_rvld_1;
    logic [DATA_W-1:0]     r_rdata_0;
    logic [DATA_W-1:0]     r_rdata_1;
    logic                  r_ram_wren;

    logic                  w_win;
    logic                  w_any;
    logic                  w_win_we;
    logic [ADDR_W-1:0]     w_win_addr;
    logic [DATA_W-1:0]     w_win_wdata;

    rr_arb2 u_rr_arb2 (
        .req   ({bus.req_1, bus.req_0}),
        .last  (r_last_gnt),
        .fixed (c_FIXED_PRIO),
        .win   (w_win),
        .any   (w_any)
    );

    always_comb begin
        w_win_we    = bus.we_0;
        w_win_addr  = bus.addr_0;
        w_win_wdata = bus.wdata_0;
        if (w_win == OWN_1) begin
            w_win_we    = bus.we_1;
            w_win_addr  = bus.addr_1;
            w_win_wdata = bus.wdata_1;
        end
    end

    // Write enable is launched from IDLE so it is high exactly in the ACC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_owner <= OWN_0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_last_gnt  <= OWN_1;
            r_wait_cnt  <= '0;
            r_gnt_0     <= 1'b0;
            r_gnt_1     <= 1'b0;
            r_rvld_0    <= 1'b0;
            r_rvld_1    <= 1'b0;
            r_rdata_0   <= '0;
            r_rdata_1   <= '0;
            r_ram_wren  <= 1'b0;
        end else begin
            r_gnt_0    <= 1'b0;
            r_gnt_1    <= 1'b0;
            r_rvld_0   <= 1'b0;
            r_rvld_1   <= 1'b0;
            r_ram_wren <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_cmd_owner <= w_win;
                        r_cmd_we    <= w_win_we;
                        r_cmd_addr  <= w_win_addr;
                        r_cmd_wdata <= w_win_wdata;
                        r_last_gnt  <= w_win;
                        r_gnt_0     <= (w_win == OWN_0);
                        r_gnt_1     <= (w_win == OWN_1);
                        r_ram_wren  <= w_win_we;
                        r_state     <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (r_cmd_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= rd_wait_init(RD_LAT);
                        r_state    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (r_cmd_owner == OWN_0) begin
                        r_rdata_0 <= bus.ram_q;
                        r_rvld_0  <= 1'b1;
                    end else begin
                        r_rdata_1 <= bus.ram_q;
                        r_rvld_1  <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM address/data come straight from the command registers
    assign bus.ram_wren   = r_ram_wren;
    assign bus.ram_wraddr = r_cmd_addr;
    assign bus.ram_wdata  = r_cmd_wdata;
    assign bus.ram_rdaddr = r_cmd_addr;

    assign bus.gnt_0   = r_gnt_0;
    assign bus.gnt_1   = r_gnt_1;
    assign bus.rvld_0  = r_rvld_0;
    assign bus.rvld_1  = r_rvld_1;
    assign bus.rdata_0 = r_rdata_0;
    assign bus.rdata_1 = r_rdata_1;
    assign bus.busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter; three instances cover
//            RD_LAT = 1, 2, 3 with behavioural RAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct { int cyc; logic owner; } gnt_e_t;
    typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; } wr_e_t;
    typedef struct { int cyc; logic owner; logic [7:0] data; } rd_e_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_last = 1'b1;

    gnt_e_t q_gnt[$];
    wr_e_t  q_wr[$];
    rd_e_t  q_rd[$];
    rd_e_t  q_rd2[$];
    rd_e_t  q_rd3[$];

    mem_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();
    mem_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus2 ();
    mem_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus3 ();

    mem_arbiter #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
    mem_arbiter #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));
    mem_arbiter #(.DATA_W(8), .ADDR_W(4), .RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM models: address captured at the edge, q valid RD_LAT cycles later
    logic [7:0] mem1 [0:15];
    logic [7:0] mem2 [0:15];
    logic [7:0] mem3 [0:15];
    logic [7:0] q1, p2, q2, p3a, p3b, q3;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i[3:0]] <= (i == 15) ? 8'h5C : 8'h00;
                mem2[i[3:0]] <= (i == 15) ? 8'h5C : 8'h00;
                mem3[i[3:0]] <= (i == 15) ? 8'h5C : 8'h00;
            end
        end else begin
            if (bus1.ram_wren) mem1[bus1.ram_wraddr] <= bus1.ram_wdata;
            if (bus2.ram_wren) mem2[bus2.ram_wraddr] <= bus2.ram_wdata;
            if (bus3.ram_wren) mem3[bus3.ram_wraddr] <= bus3.ram_wdata;
        end
        q1  <= mem1[bus1.ram_rdaddr];
        p2  <= mem2[bus2.ram_rdaddr];
        q2  <= p2;
        p3a <= mem3[bus3.ram_rdaddr];
        p3b <= p3a;
        q3  <= p3b;
    end

    assign bus1.ram_q = q1;
    assign bus2.ram_q = q2;
    assign bus3.ram_q = q3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual unexpected pulse, required none (cycle %0d)", name, cyc);
    endtask

    // Monitor for the RD_LAT=1 instance: grants, RAM writes, read returns
    initial begin
        gnt_e_t g;
        wr_e_t  w;
        rd_e_t  r;
        forever begin
            @(negedge clk);
            if (bus1.gnt_0 === 1'b1 || bus1.gnt_1 === 1'b1) begin
                if (q_gnt.size() == 0) unexp("gnt");
                else begin
                    g = q_gnt.pop_front();
                    chk("gnt_cycle", cyc, g.cyc);
                    chk("gnt_vec", {bus1.gnt_1, bus1.gnt_0}, g.owner ? 32'd2 : 32'd1);
                end
            end
            if (bus1.ram_wren === 1'b1) begin
                if (q_wr.size() == 0) unexp("ram_wren");
                else begin
                    w = q_wr.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("wr_addr", bus1.ram_wraddr, w.addr);
                    chk("wr_data", bus1.ram_wdata, w.data);
                end
            end
            if (bus1.rvld_0 === 1'b1 || bus1.rvld_1 === 1'b1) begin
                if (q_rd.size() == 0) unexp("rvld");
                else begin
                    r = q_rd.pop_front();
                    chk("rvld_cycle", cyc, r.cyc);
                    chk("rvld_vec", {bus1.rvld_1, bus1.rvld_0}, r.owner ? 32'd2 : 32'd1);
                    chk("rdata", r.owner ? bus1.rdata_1 : bus1.rdata_0, r.data);
                end
            end
        end
    end

    // Read-return monitor for the RD_LAT=2 and RD_LAT=3 instances
    initial begin
        rd_e_t r;
        forever begin
            @(negedge clk);
            if (bus2.rvld_0 === 1'b1 || bus2.rvld_1 === 1'b1) begin
                if (q_rd2.size() == 0) unexp("rvld_lat2");
                else begin
                    r = q_rd2.pop_front();
                    chk("lat2_rvld_cycle", cyc, r.cyc);
                    chk("lat2_rvld_vec", {bus2.rvld_1, bus2.rvld_0}, r.owner ? 32'd2 : 32'd1);
                    chk("lat2_rdata", r.owner ? bus2.rdata_1 : bus2.rdata_0, r.data);
                end
            end
            if (bus3.rvld_0 === 1'b1 || bus3.rvld_1 === 1'b1) begin
                if (q_rd3.size() == 0) unexp("rvld_lat3");
                else begin
                    r = q_rd3.pop_front();
                    chk("lat3_rvld_cycle", cyc, r.cyc);
                    chk("lat3_rvld_vec", {bus3.rvld_1, bus3.rvld_0}, r.owner ? 32'd2 : 32'd1);
                    chk("lat3_rdata", r.owner ? bus3.rdata_1 : bus3.rdata_0, r.data);
                end
            end
        end
    end

    // One uncontended access on instance 1; returns once the FSM is back in IDLE
    task automatic single1(input logic who, input logic we, input logic [3:0] a,
                           input logic [7:0] d, input logic [7:0] rd);
        int t;
        t = cyc;
        if (!who) begin
            bus1.req_0 = 1'b1; bus1.we_0 = we; bus1.addr_0 = a; bus1.wdata_0 = d;
        end else begin
            bus1.req_1 = 1'b1; bus1.we_1 = we; bus1.addr_1 = a; bus1.wdata_1 = d;
        end
        q_gnt.push_back('{t + 1, who});
        if (we) q_wr.push_back('{t + 1, a, d});
        else    q_rd.push_back('{t + 4, who, rd});
        exp_last = who;
        @(posedge clk); #1;
        bus1.req_0 = 1'b0;
        bus1.req_1 = 1'b0;
        repeat (we ? 1 : 3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic w;
        logic [3:0] n0, n1;
        {bus1.req_0, bus1.we_0, bus1.addr_0, bus1.wdata_0} = '0;
        {bus1.req_1, bus1.we_1, bus1.addr_1, bus1.wdata_1} = '0;
        {bus2.req_0, bus2.we_0, bus2.addr_0, bus2.wdata_0} = '0;
        {bus2.req_1, bus2.we_1, bus2.addr_1, bus2.wdata_1} = '0;
        {bus3.req_0, bus3.we_0, bus3.addr_0, bus3.wdata_0} = '0;
        {bus3.req_1, bus3.we_1, bus3.addr_1, bus3.wdata_1} = '0;
        repeat (3) @(posedge clk);
        #1;
        init = 1'b0;
        chk("rst_gnt", {bus1.gnt_1, bus1.gnt_0}, 0);
        chk("rst_rvld", {bus1.rvld_1, bus1.rvld_0}, 0);
        chk("rst_wren", bus1.ram_wren, 0);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_rdata", {bus1.rdata_1, bus1.rdata_0}, 0);
        chk("rst_wraddr", bus1.ram_wraddr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read back, both requesters
        single1(1'b0, 1'b1, 4'h3, 8'hA5, 8'h00);
        single1(1'b0, 1'b0, 4'h3, 8'h00, 8'hA5);
        single1(1'b1, 1'b1, 4'h7, 8'h3C, 8'h00);
        single1(1'b1, 1'b0, 4'h7, 8'h00, 8'h3C);
        chk("rdata_0_hold", bus1.rdata_0, 8'hA5);

        // Both requesters continuously issue distinct writes
        bus1.we_0 = 1'b1; bus1.we_1 = 1'b1; n0 = 4'd0; n1 = 4'd0;
        for (int k = 0; k < 6; k++) begin
            t = cyc;
            bus1.req_0 = 1'b1; bus1.req_1 = 1'b1;
            bus1.addr_0 = 4'h8 + n0; bus1.wdata_0 = 8'h10 + {4'h0, n0};
            bus1.addr_1 = 4'hC + n1; bus1.wdata_1 = 8'h20 + {4'h0, n1};
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ~exp_last;
`endif
            exp_last = w;
            q_gnt.push_back('{t + 1, w});
            if (w) q_wr.push_back('{t + 1, bus1.addr_1, bus1.wdata_1});
            else   q_wr.push_back('{t + 1, bus1.addr_0, bus1.wdata_0});
            @(posedge clk); #1;
            if (w) n1++; else n0++;
            if (k == 5) begin bus1.req_0 = 1'b0; bus1.req_1 = 1'b0; end
            @(posedge clk); #1;
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        single1(1'b1, 1'b0, 4'hC, 8'h00, 8'h14);
`else
        single1(1'b1, 1'b0, 4'hC, 8'h00, 8'h20);
`endif
        single1(1'b0, 1'b0, 4'h9, 8'h00, 8'h11);

        // Requester 1 withdraws while requester 0's read is served
        t = cyc;
        bus1.req_0 = 1'b1; bus1.we_0 = 1'b0; bus1.addr_0 = 4'h3;
        q_gnt.push_back('{t + 1, 1'b0});
        q_rd.push_back('{t + 4, 1'b0, 8'hA5});
        @(posedge clk); #1;
        bus1.req_0 = 1'b0;
        bus1.req_1 = 1'b1; bus1.we_1 = 1'b1; bus1.addr_1 = 4'h2; bus1.wdata_1 = 8'hEE;
        repeat (3) begin @(posedge clk); #1; end
        bus1.req_1 = 1'b0;
        bus1.req_0 = 1'b1; bus1.we_0 = 1'b1; bus1.addr_0 = 4'h5; bus1.wdata_0 = 8'h77;
        q_gnt.push_back('{t + 5, 1'b0});
        q_wr.push_back('{t + 5, 4'h5, 8'h77});
        @(posedge clk); #1;
        bus1.req_0 = 1'b0;
        @(posedge clk); #1;

        // Longer read latencies: requester 1 reads preloaded address F
        t = cyc;
        bus2.req_1 = 1'b1; bus2.we_1 = 1'b0; bus2.addr_1 = 4'hF;
        bus3.req_1 = 1'b1; bus3.we_1 = 1'b0; bus3.addr_1 = 4'hF;
        q_rd2.push_back('{t + 5, 1'b1, 8'h5C});
        q_rd3.push_back('{t + 6, 1'b1, 8'h5C});
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin bus2.req_1 = 1'b0; bus3.req_1 = 1'b0; end
            chk("lat2_busy_gnt", {bus2.busy, bus2.gnt_1, bus2.gnt_0}, {(c <= 4), (c == 1), 1'b0});
            chk("lat3_busy_gnt", {bus3.busy, bus3.gnt_1, bus3.gnt_0}, {(c <= 5), (c == 1), 1'b0});
        end

        // Reset during a read wait on instance 3 and a write cycle on instance 1
        bus3.req_1 = 1'b1; bus3.we_1 = 1'b0; bus3.addr_1 = 4'hF;
        @(posedge clk); #1;
        bus3.req_1 = 1'b0;
        bus1.req_0 = 1'b1; bus1.we_0 = 1'b1; bus1.addr_0 = 4'h6; bus1.wdata_0 = 8'h99;
        @(posedge clk); #1;
        bus1.req_0 = 1'b0;
        chk("cut_wren_pre", bus1.ram_wren, 1);
        chk("cut_busy3_pre", bus3.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("cut_wren", bus1.ram_wren, 0);
        chk("cut_gnt", {bus1.gnt_1, bus1.gnt_0}, 0);
        chk("cut_busy1", bus1.busy, 0);
        chk("cut_rdata0", bus1.rdata_0, 0);
        chk("cut_busy3", bus3.busy, 0);
        chk("cut_rvld3", {bus3.rvld_1, bus3.rvld_0}, 0);
        chk("cut_rdata3", bus3.rdata_1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_last = 1'b1;
        @(posedge clk); #1;

        // First contended request after reset goes to requester 0
        t = cyc;
        bus1.req_0 = 1'b1; bus1.we_0 = 1'b1; bus1.addr_0 = 4'h1; bus1.wdata_0 = 8'h42;
        bus1.req_1 = 1'b1; bus1.we_1 = 1'b1; bus1.addr_1 = 4'h2; bus1.wdata_1 = 8'h43;
        q_gnt.push_back('{t + 1, 1'b0});
        q_wr.push_back('{t + 1, 4'h1, 8'h42});
        q_gnt.push_back('{t + 3, 1'b1});
        q_wr.push_back('{t + 3, 4'h2, 8'h43});
        @(posedge clk); #1;
        bus1.req_0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus1.req_1 = 1'b0;
        @(posedge clk); #1;
        chk("busy3_after_rst", bus3.busy, 0);
        single1(1'b0, 1'b0, 4'h6, 8'h00, 8'h00);
        single1(1'b1, 1'b0, 4'h1, 8'h00, 8'h42);

        repeat (8) @(posedge clk);
        #1;
        chk("q_gnt_left", q_gnt.size(), 0);
        chk("q_wr_left", q_wr.size(), 0);
        chk("q_rd_left", q_rd.size(), 0);
        chk("q_rd2_left", q_rd2.size(), 0);
        chk("q_rd3_left", q_rd3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
